// File: rtl/bus_arb_if.sv
// ---------------------------------------------------------------------------
// bus_arb_if -- signal bundle between the bus masters / memory controller and
// the bus arbiter.
//
// Signals:
//   req    [3:0]  per-master bus request (0 = GPU, 1 = DSP, 2 = blitter, 3 = 68k)
//   lock   [3:0]  per-master hold request, blocks quantum preemption of owner
//   ack           memory controller accepted the current cycle
//   gnt    [3:0]  one-hot registered grant, or all zero
//   owner  [1:0]  index of the current or most recent grantee
//   busy          arbiter is in the OWN state
//   ackerr        one-cycle pulse: ack seen while no master owned the bus
//
// Modports:
//   slave  -- the arbiter side (consumes req/lock/ack, drives grant status)
//   master -- the requester / environment side
// ---------------------------------------------------------------------------
interface bus_arb_if;
   logic [3:0] req;
   logic [3:0] lock;
   logic       ack;
   logic [3:0] gnt;
   logic [1:0] owner;
   logic       busy;
   logic       ackerr;

   modport slave (
      input  req,
      input  lock,
      input  ack,
      output gnt,
      output owner,
      output busy,
      output ackerr
   );

   modport master (
      output req,
      output lock,
      output ack,
      input  gnt,
      input  owner,
      input  busy,
      input  ackerr
   );
endinterface

// File: rtl/bus_arb.sv
// ---------------------------------------------------------------------------
// bus_arb -- four-master bus arbiter with quantum preemption and a one-cycle
// dead-time (TURN) state between successive bus owners.
//
// Ports:
//   sys_clk  in   single clock, all state on rising edge
//   resetl   in   asynchronous active-low reset
//   bus      slave modport of bus_arb_if (req, lock, ack in; gnt, owner,
//                 busy, ackerr out)
//
// States: IDLE (nobody requests), OWN (a master holds the grant),
//         TURN (one dead cycle with gnt = 0, arbitration takes place).
//
// Configuration macro:
//   BUS_ARB_RR_EN  defined   -> round-robin selection with an rr pointer
//                  undefined -> fixed priority, lowest index wins
// ---------------------------------------------------------------------------
module bus_arb (
   input  logic     sys_clk,
   input  logic     resetl,
   bus_arb_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_gnt;
   logic [3:0] w_gnt_nxt;
   logic [1:0] r_owner;
   logic [1:0] w_owner_nxt;
   logic [2:0] r_qcnt;
   logic [2:0] w_qcnt_nxt;
   logic       r_ackerr;
   logic       w_ackerr_nxt;
`ifdef BUS_ARB_RR_EN
   logic [1:0] r_rrptr;
   logic [1:0] w_rrptr_nxt;
`endif

   logic [1:0] w_winner;
   logic [3:0] w_others;
   logic       w_preempt;

   // Quantum counter increment, sticking at 7.
   function automatic logic [2:0] f_qsat_inc(input logic [2:0] q);
      return (q == 3'd7) ? 3'd7 : q + 3'd1;
   endfunction

   function automatic logic [3:0] f_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

`ifdef BUS_ARB_RR_EN
   // Search starts one past the pointer and wraps 3 -> 0; the pointer itself
   // is visited last. Only meaningful when r != 0.
   function automatic logic [1:0] f_pick(input logic [3:0] r, input logic [1:0] ptr);
      logic [1:0] idx;
      logic [1:0] win;
      logic       found;
      win   = ptr;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr + k[1:0];
         if (!found && r[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction
`else
   function automatic logic [1:0] f_pick(input logic [3:0] r);
      if (r[0])      return 2'd0;
      else if (r[1]) return 2'd1;
      else if (r[2]) return 2'd2;
      else           return 2'd3;
   endfunction
`endif

`ifdef BUS_ARB_RR_EN
   assign w_winner = f_pick(bus.req, r_rrptr);
`else
   assign w_winner = f_pick(bus.req);
`endif

   // Preemption compares against the counter value before this ack, so the
   // eighth ack of an ownership is the one that can take the bus away.
   assign w_others  = bus.req & ~f_onehot(r_owner);
   assign w_preempt = bus.ack && (r_qcnt == 3'd7) && !bus.lock[r_owner] &&
                      (w_others != 4'b0000);

   always_comb begin
      w_state_nxt  = r_state;
      w_gnt_nxt    = r_gnt;
      w_owner_nxt  = r_owner;
      w_qcnt_nxt   = r_qcnt;
      w_ackerr_nxt = 1'b0;
`ifdef BUS_ARB_RR_EN
      w_rrptr_nxt  = r_rrptr;
`endif
      case (r_state)
         ST_OWN: begin
            // An ack still counts even when the owner is leaving this cycle.
            if (bus.ack) begin
               w_qcnt_nxt = f_qsat_inc(r_qcnt);
            end
            if (!bus.req[r_owner] || w_preempt) begin
               w_gnt_nxt   = 4'b0000;
               w_state_nxt = ST_TURN;
            end
         end
         default: begin
            // IDLE and TURN arbitrate identically; any ack here is stray.
            w_ackerr_nxt = bus.ack;
            if (bus.req != 4'b0000) begin
               w_state_nxt = ST_OWN;
               w_gnt_nxt   = f_onehot(w_winner);
               w_owner_nxt = w_winner;
               w_qcnt_nxt  = 3'd0;
`ifdef BUS_ARB_RR_EN
               w_rrptr_nxt = w_winner;
`endif
            end else begin
               w_state_nxt = ST_IDLE;
               w_gnt_nxt   = 4'b0000;
            end
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         r_state  <= ST_IDLE;
         r_gnt    <= 4'b0000;
         r_owner  <= 2'd0;
         r_qcnt   <= 3'd0;
         r_ackerr <= 1'b0;
`ifdef BUS_ARB_RR_EN
         r_rrptr  <= 2'd3;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= w_gnt_nxt;
         r_owner  <= w_owner_nxt;
         r_qcnt   <= w_qcnt_nxt;
         r_ackerr <= w_ackerr_nxt;
`ifdef BUS_ARB_RR_EN
         r_rrptr  <= w_rrptr_nxt;
`endif
      end
   end

   assign bus.gnt    = r_gnt;
   assign bus.owner  = r_owner;
   assign bus.busy   = (r_state == ST_OWN);
   assign bus.ackerr = r_ackerr;

endmodule
